spi_slave_rx16: RTL and testbench

- SPI slave front end that deserialises 16-bit command words from the host and presents them to the FPGA controller as a held parallel word (RX_DATA) plus a one-cycle strobe.
- Serialises a 16-bit response word (e.g. photon count) back to the host on MISO.
- SPI mode 0, MSB first, oversampled in the CLK domain. Sits directly upstream of the controller, driving its rx input.

---
 rtl/spi_slave_rx16.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_rx16.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx16.sv
// ============================================================================
//  Module   : spi_slave_rx16
//  Purpose  : SPI mode-0 slave, MSB first, oversampled in the CLK domain.
//             Deserialises WIDTH-bit command words into a held parallel word
//             with a one-cycle strobe. Serialises a response word on MISO.
//  Ports    : CLK, RST       - system clock, async active-high reset
//             SCK/SSEL/MOSI  - SPI pins from host (asynchronous to CLK)
//             MISO           - serial response to host
//             TX_DATA        - response word, captured at each load point
//             RX_DATA        - last complete received word (held)
//             RX_VALID       - one-CLK pulse when RX_DATA updates
//             TX_LOAD        - one-CLK pulse when TX_DATA is captured
//             BUSY           - synchronised chip-select is active
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_rx16 #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SCK,
    input  logic             SSEL,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] TX_DATA,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             TX_LOAD,
    output logic             BUSY
);

    localparam int             CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ssel_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_dly_q;
    logic                   ssel_dly_q;
    // fill_q tracks how many chain stages hold genuine pin samples since
    // reset release; arm_q is set only once SSEL has truly been seen high,
    // so an SSEL already low at reset release cannot fake a frame start.
    logic [SYNC_STAGES:0]   fill_q;
    logic                   arm_q;

    logic w_sck;
    logic w_ssel;
    logic w_mosi;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_ssel_fall;
    logic w_ssel_rise;

    assign w_sck       = sck_sync_q[SYNC_STAGES-1];
    assign w_ssel      = ssel_sync_q[SYNC_STAGES-1];
    // Same stage as SCK so the data bit lines up with w_sck_rise.
    assign w_mosi      = mosi_sync_q[SYNC_STAGES-1];
    assign w_sck_rise  =  w_sck  & ~sck_dly_q;
    assign w_sck_fall  = ~w_sck  &  sck_dly_q;
    assign w_ssel_fall = ~w_ssel &  ssel_dly_q;
    assign w_ssel_rise =  w_ssel & ~ssel_dly_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sck_sync_q  <= '0;
            ssel_sync_q <= '1;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            ssel_dly_q  <= 1'b1;
            fill_q      <= '0;
            arm_q       <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  SCK};
            ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], SSEL};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sck_dly_q   <= w_sck;
            ssel_dly_q  <= w_ssel;
            fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            if (fill_q[SYNC_STAGES] && w_ssel && ssel_dly_q) begin
                arm_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine and datapath
    // ------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [WIDTH-2:0] rx_shift_q, rx_shift_d;   // bits gathered so far
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_load_q,  tx_load_d;
    // Set by a word-boundary reload: the next SCK fall must keep the freshly
    // loaded MSB on MISO rather than shifting it away.
    logic             skip_q,     skip_d;

    logic [WIDTH-1:0] w_word;
    assign w_word = {rx_shift_q, w_mosi};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            skip_q     <= skip_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        skip_d     = skip_q;

        case (state_q)
            ST_IDLE: begin
                // SCK/MOSI activity is ignored here; a simultaneous SCK
                // edge at frame start is dropped by construction.
                if (w_ssel_fall && arm_q) begin
                    state_d    = ST_ACTIVE;
                    cnt_d      = '0;
                    tx_shift_d = TX_DATA;
                    tx_load_d  = 1'b1;
                    skip_d     = 1'b0;
                end
            end

            ST_ACTIVE: begin
                if (w_sck_rise) begin
                    rx_shift_d = w_word[WIDTH-2:0];
                    if (cnt_q == C_CNT_LAST) begin
                        rx_data_d  = w_word;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        tx_shift_d = TX_DATA;
                        tx_load_d  = 1'b1;
                        skip_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (w_sck_fall) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                    end
                end

                // Evaluated after the SCK handling so a word finishing in
                // the same cycle still completes before returning to idle.
                if (w_ssel_rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    skip_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign TX_LOAD  = tx_load_q;
    assign BUSY     = (state_q == ST_ACTIVE);
    assign MISO     = (state_q == ST_ACTIVE) & tx_shift_q[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_rx16.sv
// ============================================================================
//  Module   : tb_spi_slave_rx16
//  Purpose  : Self-checking bench for spi_slave_rx16. A host model drives
//             SPI frames; expected words go into a queue that a monitor
//             drains on every RX_VALID.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_rx16;

    localparam int W = 16;
    localparam int S = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          SCK = 1'b0;
    logic          SSEL = 1'b1;
    logic          MOSI = 1'b0;
    logic [W-1:0]  TX_DATA = '0;
    logic          MISO;
    logic [W-1:0]  RX_DATA;
    logic          RX_VALID;
    logic          TX_LOAD;
    logic          BUSY;

    spi_slave_rx16 #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SCK      (SCK),
        .SSEL     (SSEL),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .TX_DATA  (TX_DATA),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .TX_LOAD  (TX_LOAD),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int           load_cnt  = 0;
    int           valid_cnt = 0;
    longint       t_valid   = 0;
    logic         prev_v    = 1'b0;
    logic         prev_l    = 1'b0;

    always @(negedge CLK) begin
        if (RX_VALID) begin
            valid_cnt++;
            t_valid = $time;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rx_unexpected: got RX_VALID with RX_DATA 0x%0h, expected no word", RX_DATA);
            end else begin
                check("rx_word", RX_DATA, exp_q.pop_front());
            end
            if (prev_v) begin
                n_checks++;
                $display("FAIL rx_valid_width: got RX_VALID high 2+ cycles, expected 1");
            end
        end
        if (TX_LOAD) begin
            load_cnt++;
            if (prev_l) begin
                n_checks++;
                $display("FAIL tx_load_width: got TX_LOAD high 2+ cycles, expected 1");
            end
        end
        prev_v = RX_VALID;
        prev_l = TX_LOAD;
    end

    // ------------------------------------------------------------------
    // Host model: words to send and responses the slave should return
    // ------------------------------------------------------------------
    logic [W-1:0] mosi_w [4];
    logic [W-1:0] tx_w   [5];
    logic [W-1:0] exp_hold = '0;
    longint       t_last_rise = 0;

    // nwords full words, then part_bits of an aborted word (0 = none).
    // simul_end raises SSEL together with the final SCK rise.
    task automatic run_frame(input int nwords, input int part_bits, input int half,
                             input bit simul_end);
        int           loads0;
        int           nb;
        logic [W-1:0] got;
        @(negedge CLK);
        loads0  = load_cnt;
        TX_DATA = tx_w[0];
        SSEL    = 1'b0;
        #40;
        for (int w = 0; w < nwords + ((part_bits > 0) ? 1 : 0); w++) begin
            nb  = (w < nwords) ? W : part_bits;
            got = '0;
            for (int i = 0; i < nb; i++) begin
                MOSI = mosi_w[w][W-1-i];
                #(half);
                got[W-1-i] = MISO;
                if (i == W-1) begin
                    exp_q.push_back(mosi_w[w]);
                    exp_hold    = mosi_w[w];
                    t_last_rise = $time;
                end
                SCK = 1'b1;
                if (i == W-1 && simul_end && w == nwords-1) SSEL = 1'b1;
                #(half);
                SCK = 1'b0;
                if (i == 8 && w < nwords) TX_DATA = tx_w[w+1];
            end
            if (w < nwords) check("miso_word", got, tx_w[w]);
        end
        if (!simul_end) begin
            #(half);
            SSEL = 1'b1;
        end
        #100;
        check("tx_load_count", load_cnt - loads0, nwords + 1);
        check("rx_pending",    exp_q.size(), 0);
        check("busy_idle",     BUSY, 0);
        check("miso_idle",     MISO, 0);
        check("rx_hold",       RX_DATA, exp_hold);
    endtask

    initial begin
        int   loads0;
        int   valids0;
        logic quiet_bad;
        int   nw;
        int   pb;

        // Reset state
        #23;
        check("rst_rx_data",  RX_DATA, 0);
        check("rst_rx_valid", RX_VALID, 0);
        check("rst_tx_load",  TX_LOAD, 0);
        check("rst_miso",     MISO, 0);
        check("rst_busy",     BUSY, 0);
        @(negedge CLK);
        RST = 1'b0;
        #100;

        // Single word 0x0001, CLK = 8x SCK, latency check
        mosi_w[0] = 16'h0001; tx_w[0] = 16'h5A5A; tx_w[1] = 16'h0F0F;
        run_frame(1, 0, 40, 1'b0);
        check("rx_latency", 32'(t_valid - t_last_rise), 10 * (S + 1));

        // Response 0xA5C3 on MISO
        mosi_w[0] = 16'h0003; tx_w[0] = 16'hA5C3; tx_w[1] = 16'h0000;
        run_frame(1, 0, 40, 1'b0);

        // Two words in one frame, TX_DATA changed between them
        mosi_w[0] = 16'h0003; mosi_w[1] = 16'h0000;
        tx_w[0] = 16'h1234; tx_w[1] = 16'hBEEF; tx_w[2] = 16'h7777;
        run_frame(2, 0, 40, 1'b0);

        // Abort after 9 bits of 0xFFFF; prior word must stay, next decodes
        mosi_w[0] = 16'h0001; tx_w[0] = 16'h1111; tx_w[1] = 16'h2222;
        run_frame(1, 0, 40, 1'b0);
        mosi_w[0] = 16'hFFFF;
        run_frame(0, 9, 40, 1'b0);
        mosi_w[0] = 16'h0003; tx_w[0] = 16'h3333; tx_w[1] = 16'h4444;
        run_frame(1, 0, 40, 1'b0);

        // SCK activity with SSEL high is ignored
        @(negedge CLK);
        loads0 = load_cnt; valids0 = valid_cnt; quiet_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            MOSI = 1'($urandom);
            SCK  = 1'b1; #30;
            quiet_bad |= MISO | BUSY;
            SCK  = 1'b0; #30;
            quiet_bad |= MISO | BUSY;
        end
        #50;
        check("idle_quiet",  quiet_bad, 0);
        check("idle_loads",  load_cnt - loads0, 0);
        check("idle_valids", valid_cnt - valids0, 0);

        // Reset mid-frame, SSEL held low across release
        @(negedge CLK);
        TX_DATA = 16'hFFFF; SSEL = 1'b0; #40;
        for (int i = 0; i < 8; i++) begin
            MOSI = 1'b1; #40; SCK = 1'b1; #40; SCK = 1'b0;
        end
        RST = 1'b1;
        #1;
        check("mid_rst_rx_data",  RX_DATA, 0);
        check("mid_rst_rx_valid", RX_VALID, 0);
        check("mid_rst_tx_load",  TX_LOAD, 0);
        check("mid_rst_miso",     MISO, 0);
        check("mid_rst_busy",     BUSY, 0);
        exp_hold = '0;
        @(negedge CLK);
        RST = 1'b0;
        loads0 = load_cnt; valids0 = valid_cnt; quiet_bad = 1'b0;
        for (int i = 0; i < W; i++) begin
            MOSI = 1'($urandom); #40; SCK = 1'b1;
            quiet_bad |= BUSY;
            #40; SCK = 1'b0;
        end
        #50;
        check("post_rst_busy",   quiet_bad, 0);
        check("post_rst_loads",  load_cnt - loads0, 0);
        check("post_rst_valids", valid_cnt - valids0, 0);
        check("post_rst_rxdata", RX_DATA, 0);
        SSEL = 1'b1;
        #100;
        mosi_w[0] = 16'hC0DE; tx_w[0] = 16'h8001; tx_w[1] = 16'h0000;
        run_frame(1, 0, 40, 1'b0);

        // SSEL rise coincident with the final SCK rise
        mosi_w[0] = 16'h1357; mosi_w[1] = 16'h9BDF;
        tx_w[0] = 16'h2468; tx_w[1] = 16'hACE0; tx_w[2] = 16'h0101;
        run_frame(2, 0, 40, 1'b1);

        // Randomised frames
        for (int r = 0; r < 20; r++) begin
            nw = int'($urandom_range(1, 3));
            pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
            for (int j = 0; j < 4; j++) mosi_w[j] = W'($urandom);
            for (int j = 0; j < 5; j++) tx_w[j]   = W'($urandom);
            run_frame(nw, pb, 10 * int'($urandom_range(3, 6)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
